vga_vram_arbiter: RTL

//  Time-slot scheduler for the single-port frame RAM (FB_W x FB_H words, each word = one 4x4 screen block).

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/vram_scan_addr.sv | 34 +++
 rtl/vga_vram_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants and 4x4-block framebuffer geometry, shared by the
// timing generator and the VRAM arbiter.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned SCALE_LOG2 = 2;
  localparam int unsigned FB_W       = H_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_H       = V_ACTIVE >> SCALE_LOG2;
  localparam int unsigned FB_WORDS   = FB_W * FB_H;
  localparam int unsigned H_GROUPS   = H_TOTAL >> SCALE_LOG2;

endpackage

// File: rtl/vram_scan_addr.sv
// Scanout address decode: from the current counters, finds the next 4-pixel group,
// whether it is visible, and whether this cycle is its fetch slot or its load edge.
module vram_scan_addr
  import vga_timing_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  output logic              disp_slot,
  output logic              load_edge,
  output logic              in_active,
  output logic [ADDR_W-1:0] scan_addr
);

  logic [7:0] grp_next;
  logic [9:0] line_next;
  logic [9:0] tgt_line;
  logic [6:0] row;

  always_comb begin
    // Group 0 is fetched at the end of the previous line, so it targets the next line.
    grp_next  = (h_count[9:2] == 8'(H_GROUPS - 1)) ? 8'd0 : h_count[9:2] + 8'd1;
    line_next = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
    tgt_line  = (grp_next == 8'd0) ? line_next : v_count;
    in_active = (grp_next < 8'(FB_W)) && (tgt_line < 10'(V_ACTIVE));
    disp_slot = in_active && (h_count[1:0] == 2'b00);
    load_edge = (h_count[1:0] == 2'b11);
    row       = 7'(tgt_line >> SCALE_LOG2);
    // row * 160 without a multiplier
    scan_addr = (ADDR_W'(row) << 7) + (ADDR_W'(row) << 5) + ADDR_W'(grp_next);
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port frame RAM scheduler: one scanout read per 4-pixel group, all other cycles to
// the writer. Define VRAM_ARB_STATS_EN to add the stall_cnt / oor_flag statistics ports.
module vga_vram_arbiter
  import vga_timing_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        h_count,
  input  logic [9:0]        v_count,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_color
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic              oor_flag
`endif
);

  logic              disp_slot;
  logic              load_edge;
  logic              in_active;
  logic [ADDR_W-1:0] scan_addr;
  logic              wr_in_range;
  logic              slot_q;
  logic [DATA_W-1:0] pf_q;

  vram_scan_addr #(
    .ADDR_W(ADDR_W)
  ) u_scan (
    .h_count  (h_count),
    .v_count  (v_count),
    .disp_slot(disp_slot),
    .load_edge(load_edge),
    .in_active(in_active),
    .scan_addr(scan_addr)
  );

  always_comb begin
    wr_in_range = (wr_addr < ADDR_W'(FB_WORDS));
    wr_ack      = wr_req && !rst && !disp_slot;
    ram_addr    = disp_slot ? scan_addr : wr_addr;
    // Out-of-range writes are acknowledged but never reach the RAM.
    ram_we      = wr_ack && wr_in_range;
    ram_wdata   = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= 1'b0;
      pf_q      <= '0;
      pix_color <= '0;
    end else begin
      slot_q <= disp_slot;
      if (slot_q) begin
        pf_q <= ram_rdata;
      end
      if (load_edge) begin
        pix_color <= in_active ? pf_q : '0;
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      oor_flag  <= 1'b0;
    end else begin
      if (wr_req && !wr_ack && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (wr_ack && !wr_in_range) begin
        oor_flag <= 1'b1;
      end
    end
  end
`endif

endmodule
